// File: rtl/key_flow_ctrl_pkg.sv
// Shared constants for the key input path feeding the light-flow pattern generator.
// Key-to-function mapping, the speed type and the control-register defaults live here.
package lightflow_pkg;

  localparam int KEY_RUN     = 0;
  localparam int KEY_DIR     = 1;
  localparam int KEY_SPEED   = 2;
  localparam int KEY_DEFAULT = 3;

  typedef logic [1:0] speed_t;

  localparam logic   DEF_RUN   = 1'b1;
  localparam logic   DEF_DIR   = 1'b0;
  localparam speed_t DEF_SPEED = 2'd0;

  localparam int DEBOUNCE_DEFAULT = 2400;

endpackage

// File: rtl/key_flow_ctrl_if.sv
// Bundle between the board key pins / light-flow consumer and key_flow_ctrl.
// The master side drives the raw keys; the slave side (key_flow_ctrl) drives the outputs.
interface key_flow_ctrl_if #(
  parameter int NKEYS = 4
);
  import lightflow_pkg::*;

  logic [NKEYS-1:0] key_n;
  logic [NKEYS-1:0] key_level;
  logic [NKEYS-1:0] key_press;
  logic             run_en;
  logic             flow_dir;
  speed_t           speed_sel;

  modport master (
    output key_n,
    input  key_level, key_press, run_en, flow_dir, speed_sel
  );

  modport slave (
    input  key_n,
    output key_level, key_press, run_en, flow_dir, speed_sel
  );

endinterface

// File: rtl/key_flow_ctrl_debounce.sv
// One push button: synchroniser, debounce counter, stable level and a one-cycle press pulse.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module key_debounce
  import lightflow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable;
  logic [CNT_W-1:0]       cnt;

  assign synced = sync_q[SYNC_STAGES-1];

  // key_level trails stable by one edge, so a low stable with a still-low level marks the press edge
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      stable    <= 1'b1;
      cnt       <= '0;
      key_level <= 1'b0;
      key_press <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      key_level <= ~stable;
      key_press <= ~stable & ~key_level;
    end
  end

endmodule

// File: rtl/key_flow_ctrl.sv
// Key front end for the light-flow block: per-key debouncers plus the run/direction/speed register.
// Only keys 0..3 affect the control register; higher keys just report level and press.
module key_flow_ctrl
  import lightflow_pkg::*;
#(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input logic            clk_in,
  input logic            rst_n,
  key_flow_ctrl_if.slave bus
);

  logic [NKEYS-1:0] level_w;
  logic [NKEYS-1:0] press_w;
  logic             run_q;
  logic             dir_q;
  speed_t           speed_q;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_key (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .key_n     (bus.key_n[i]),
      .key_level (level_w[i]),
      .key_press (press_w[i])
    );
  end

  // The default key wins outright; the other three keys act independently in the same cycle
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= DEF_RUN;
      dir_q   <= DEF_DIR;
      speed_q <= DEF_SPEED;
    end else if (press_w[KEY_DEFAULT]) begin
      run_q   <= DEF_RUN;
      dir_q   <= DEF_DIR;
      speed_q <= DEF_SPEED;
    end else begin
      if (press_w[KEY_RUN])   run_q   <= ~run_q;
      if (press_w[KEY_DIR])   dir_q   <= ~dir_q;
      if (press_w[KEY_SPEED]) speed_q <= speed_q + speed_t'(1);
    end
  end

  assign bus.key_level = level_w;
  assign bus.key_press = press_w;
  assign bus.run_en    = run_q;
  assign bus.flow_dir  = dir_q;
  assign bus.speed_sel = speed_q;

endmodule

// File: tb/tb_key_flow_ctrl.sv
// Self-checking bench for key_flow_ctrl with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// A sliding-window reference model predicts every output; directed tasks add fixed-value checks.
module tb_key_flow_ctrl;

  localparam int NK = 4;
  localparam int D  = 4;
  localparam int S  = 2;
  localparam logic [11:0] RESET_VEC = 12'b0000_0000_1_0_00;

  logic clk_in;
  logic rst_n;
  int   total;
  int   bad;

  key_flow_ctrl_if #(.NKEYS(NK)) bus ();

  key_flow_ctrl #(
    .NKEYS           (NK),
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Model: a level flips once the D samples seen through the S-deep synchroniser all disagree with it
  bit          hist [NK][$];
  logic [NK-1:0] m_stable, m_level, m_press, pend;
  logic          m_run, m_dir;
  logic [1:0]    m_speed;
  logic [11:0]   obs_vec, exp_vec;

  assign obs_vec = {bus.key_level, bus.key_press, bus.run_en, bus.flow_dir, bus.speed_sel};
  assign exp_vec = {m_level, m_press, m_run, m_dir, m_speed};

  always @(posedge clk_in or negedge rst_n) begin
    logic [NK-1:0] old_press;
    bit            all_diff;
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) begin
        hist[k].delete();
        for (int j = 0; j < S + D; j++) hist[k].push_back(1'b1);
      end
      m_stable = '1;
      m_level  = '0;
      m_press  = '0;
      pend     = '0;
      m_run    = 1'b1;
      m_dir    = 1'b0;
      m_speed  = 2'd0;
    end else begin
      old_press = m_press;
      m_level   = ~m_stable;
      m_press   = pend;
      for (int k = 0; k < NK; k++) begin
        hist[k].push_back(bus.key_n[k]);
        void'(hist[k].pop_front());
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (hist[k][j] == m_stable[k]) all_diff = 1'b0;
        pend[k] = all_diff && m_stable[k];
        if (all_diff) m_stable[k] = ~m_stable[k];
      end
      if (old_press[3]) begin
        m_run   = 1'b1;
        m_dir   = 1'b0;
        m_speed = 2'd0;
      end else begin
        if (old_press[0]) m_run = ~m_run;
        if (old_press[1]) m_dir = ~m_dir;
        if (old_press[2]) m_speed = 2'((m_speed + 1) % 4);
      end
    end
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.key_n = '1;
    repeat (3) @(negedge clk_in);
    total++;
    if (obs_vec !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_hold obs=%b exp=%b", obs_vec, RESET_VEC);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      total++;
      if (obs_vec !== RESET_VEC) begin
        bad++;
        $display("FAIL idle c=%0d obs=%b exp=%b", c, obs_vec, RESET_VEC);
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL idle_model c=%0d obs=%b exp=%b", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_press_latency();
    bus.key_n[0] = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk_in);
      total++;
      if (bus.key_press !== ((j == 6) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL press0 edge=%0d obs=%b exp_pulse=%0d", j, bus.key_press, (j == 6));
      end
      total++;
      if (bus.run_en !== (j < 7) || bus.key_level[0] !== (j >= 6)) begin
        bad++;
        $display("FAIL run0 edge=%0d run=%b level=%b exp_run=%0d exp_level=%0d",
                 j, bus.run_en, bus.key_level[0], (j < 7), (j >= 6));
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL press0_model edge=%0d obs=%b exp=%b", j, obs_vec, exp_vec);
      end
    end
    bus.key_n[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_in);
      total++;
      if (bus.key_level[0] !== (j < 6) || bus.key_press !== 4'b0000 || bus.run_en !== 1'b0) begin
        bad++;
        $display("FAIL release0 edge=%0d level=%b press=%b run=%b", j, bus.key_level[0],
                 bus.key_press, bus.run_en);
      end
    end
  endtask

  task automatic test_bounce();
    for (int j = 0; j < 24; j++) begin
      bus.key_n[1] = (j == 3 || j >= 14);
      @(negedge clk_in);
      total++;
      if (bus.key_press[1] !== (j == 10) || (j < 20 && bus.flow_dir !== (j >= 11))) begin
        bad++;
        $display("FAIL bounce edge=%0d press1=%b dir=%b exp_press=%0d exp_dir=%0d",
                 j, bus.key_press[1], bus.flow_dir, (j == 10), (j >= 11));
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL bounce_model edge=%0d obs=%b exp=%b", j, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_speed();
    for (int p = 0; p < 4; p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        bus.key_n[2] = (ph == 1);
        for (int j = 0; j < 8; j++) begin
          @(negedge clk_in);
          total++;
          if (obs_vec !== exp_vec) begin
            bad++;
            $display("FAIL speed_model p=%0d edge=%0d obs=%b exp=%b", p, j, obs_vec, exp_vec);
          end
        end
      end
      total++;
      if (bus.speed_sel !== 2'((p + 1) % 4)) begin
        bad++;
        $display("FAIL speed_step p=%0d obs=%0d exp=%0d", p, bus.speed_sel, (p + 1) % 4);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int p = 0; p < 2; p++) begin
      bus.key_n[2] = 1'b0;
      repeat (8) @(negedge clk_in);
      bus.key_n[2] = 1'b1;
      repeat (8) @(negedge clk_in);
    end
    total++;
    if ({bus.run_en, bus.flow_dir, bus.speed_sel} !== 4'b0110) begin
      bad++;
      $display("FAIL simul_pre obs=%b exp=0110", {bus.run_en, bus.flow_dir, bus.speed_sel});
    end
    bus.key_n[0] = 1'b0;
    bus.key_n[3] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_in);
      total++;
      if (bus.key_press !== ((j == 6) ? 4'b1001 : 4'b0000) ||
          {bus.run_en, bus.flow_dir, bus.speed_sel} !== ((j >= 7) ? 4'b1000 : 4'b0110)) begin
        bad++;
        $display("FAIL simul edge=%0d press=%b ctrl=%b", j, bus.key_press,
                 {bus.run_en, bus.flow_dir, bus.speed_sel});
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL simul_model edge=%0d obs=%b exp=%b", j, obs_vec, exp_vec);
      end
    end
    bus.key_n = '1;
    repeat (8) @(negedge clk_in);
  endtask

  task automatic test_reset_mid();
    bus.key_n[0] = 1'b0;
    repeat (8) @(negedge clk_in);
    bus.key_n[0] = 1'b1;
    repeat (8) @(negedge clk_in);
    bus.key_n[2] = 1'b0;
    repeat (4) @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    total++;
    if (obs_vec !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_mid_async obs=%b exp=%b", obs_vec, RESET_VEC);
    end
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk_in);
      total++;
      if (bus.key_press[2] !== (j == 6) || bus.speed_sel !== ((j >= 7) ? 2'd1 : 2'd0)) begin
        bad++;
        $display("FAIL reset_mid edge=%0d press2=%b speed=%0d", j, bus.key_press[2], bus.speed_sel);
      end
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL reset_mid_model edge=%0d obs=%b exp=%b", j, obs_vec, exp_vec);
      end
    end
    bus.key_n[2] = 1'b1;
    repeat (8) @(negedge clk_in);
  endtask

  // Random toggling yields a mix of glitches, short bounces and genuine presses
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range((k == 3) ? 19 : 5) == 0) bus.key_n[k] = ~bus.key_n[k];
      end
      @(negedge clk_in);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL random c=%0d obs=%b exp=%b", c, obs_vec, exp_vec);
      end
    end
    bus.key_n = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL random_drain c=%0d obs=%b exp=%b", c, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_press_latency();
    test_bounce();
    test_speed();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
